ram2e_cmd_initiator: RTL and testbench
======================================

Name: ram2e_cmd_initiator

Overview:
- Apple IIe-side bus initiator for the RAM2E card's RAMWorks bank-register command interface.
- Free-runs the PHI1 bus clock from C14M.
- On request, issues back-to-back write cycles to $C073 carrying the unlock sequence FF 00 55 AA C1 AD, a command byte and an optional argument, or a single plain bank-select write.
- Used as the host model in card-level benches and as the stimulus engine for the bring-up board.

Parameters:
- CYCLE_LEN, 14, C14M ticks per bus cycle (PHI1 period); legal range 12..16.
- PHI1_HIGH, 7, ticks per cycle with PHI1 high.
- BANKREG_ROW, 8'h73, row-phase address byte of the bank register (bit0=1, bit3=0).

Ports:
- C14M  in  1  14.318 MHz master clock
- nRESET  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse; accepted only when busy=0
- single  in  1  sampled with start: 1 = plain bank write of arg only; 0 = full command sequence
- cmd  in  8  command byte (EF program, EE erase, FF reset-bank, EA bitbang, E0 set-mask), sampled with start
- arg  in  8  argument / bank byte, sampled with start
- has_arg  in  1  sampled with start; 1 appends arg after cmd (ignored when single=1)
- busy  out  1  high from the accepted start until done
- done  out  1  one-C14M pulse at end of the last bus cycle
- PHI1  out  1  bus phase clock
- Ain  out  8  multiplexed address (row/column)
- Din  out  8  6502 write data to card
- nWE  out  1  6502 write strobe, active low
- nC07X  out  1  $C07X select, active low
- nWE80  out  1  aux write, held high
- nEN80  out  1  aux enable, held high

Behaviour:
- Reset (async, nRESET=0):
  - Phase counter P=CYCLE_LEN-1; PHI1=0, Ain=0, Din=0.
  - nWE, nC07X, nWE80, nEN80 all 1; busy=0, done=0.
  - Captured request registers and byte index cleared.
  - Reset mid-transfer aborts with no done pulse.
- Phase counter P:
  - Increments 0..CYCLE_LEN-1 every C14M and wraps; runs whether idle or busy.
  - All outputs are registered and decoded from the next P, so the output value for phase k is valid during phase k.
- PHI1 = 1 for P in 0..PHI1_HIGH-1, else 0. The card sees the rising edge at P=0, so card state S=k during P=k.
- Ain:
  - BANKREG_ROW for P in 4..8 (covers the card's row latch at S7).
  - 8'h00 otherwise (the column is don't-care).
  - When idle, Ain=8'h00 at all phases.
- Active write cycle:
  - nWE=0 and nC07X=0 for P in 7..13; both 1 otherwise.
  - Din holds the current byte for P in 8..CYCLE_LEN-1 (card samples at S12); 8'h00 otherwise.
  - If CYCLE_LEN<14, the strobes and Din windows end at CYCLE_LEN-1.
- Idle cycle: nWE=1, nC07X=1, Din=0.
- Start handling:
  - start with busy=0: capture single/cmd/arg/has_arg; busy=1 next clock.
  - The first write cycle begins at the next P=0. A start seen at P=0 itself waits for the following wrap.
  - start with busy=1: ignored. No queueing.
- Sequencer states:
  - IDLE, WAIT0, XFER(idx), FINISH.
  - Byte list: single=1 gives [arg] (length 1). Otherwise [FF,00,55,AA,C1,AD,cmd] plus arg if has_arg (length 7 or 8).
  - idx advances at each P=CYCLE_LEN-1.
  - Bytes are sent in consecutive bus cycles with zero idle cycles between them (the card's command timeout is 7 idle cycles).
  - After the last byte's P=CYCLE_LEN-1: done=1 for that one clock, then busy=0 and the state returns to IDLE.
  - A new start is accepted on the clock after done. Its first byte then starts at the following P=0, leaving ≥1 idle bus cycle between transfers.
- nWE80 and nEN80 are constant 1 after reset; this block never touches aux RAM.

Decomposition:
- Shared package ram2e_pkg holds:
  - unlock sequence constants (SEQ0..SEQ5 = FF,00,55,AA,C1,AD);
  - command codes CMD_PROGRAM=EF, CMD_ERASE=EE, CMD_RESETBANK=FF, CMD_BITBANG=EA, CMD_SETMASK=E0;
  - bank register row BANKREG_ROW;
  - phase window constants (row window 4..8, strobe 7..13, data 8..13);
  - sequencer state enum.
- Sub-module ram2e_bus_cycle holds the phase counter, PHI1, Ain/Din/strobe waveform and the per-cycle "write this byte" input. The top level holds the sequencer and byte mux.

Test Plan:
- Reset release, no start → PHI1 period 14 ticks, high 7; nWE=nC07X=1 throughout; Ain=00; busy=0.
- start, single=0, cmd=E0, has_arg=1, arg=3F → exactly 8 consecutive write cycles, Din at P=12 = FF,00,55,AA,C1,AD,E0,3F; Ain=73 at P=7 of each; done once at P=13 of cycle 8; busy low next clock.
- start, single=1, arg=05 → one write cycle, Din=05 at P=12, nWE low P7..13, done after it; with the RAM2E model attached, bank register reads 05.
- start, single=0, cmd=EF, has_arg=0 → 7 cycles ending in EF; second start issued mid-transfer is ignored (cycle count stays 7).
- nRESET asserted at P=10 of byte 3 → outputs go to reset values immediately; no done pulse; after release a fresh start sends the full sequence from FF.
- start asserted exactly at P=0 → transfer begins at the next wrap (14 ticks later), not the current cycle.

Source files
------------

// File: rtl/ram2e_pkg.sv
// Shared constants for the RAM2E bank-register command initiator:
// unlock sequence, command codes, bus-phase windows and sequencer states.
package ram2e_pkg;

   localparam logic [7:0] SEQ0 = 8'hFF;
   localparam logic [7:0] SEQ1 = 8'h00;
   localparam logic [7:0] SEQ2 = 8'h55;
   localparam logic [7:0] SEQ3 = 8'hAA;
   localparam logic [7:0] SEQ4 = 8'hC1;
   localparam logic [7:0] SEQ5 = 8'hAD;

   localparam logic [7:0] CMD_PROGRAM   = 8'hEF;
   localparam logic [7:0] CMD_ERASE     = 8'hEE;
   localparam logic [7:0] CMD_RESETBANK = 8'hFF;
   localparam logic [7:0] CMD_BITBANG   = 8'hEA;
   localparam logic [7:0] CMD_SETMASK   = 8'hE0;

   localparam logic [7:0] BANKREG_ROW = 8'h73;

   // Phase windows; the data window closes at the last phase of the cycle.
   localparam logic [3:0] ROW_FIRST = 4'd4;
   localparam logic [3:0] ROW_LAST  = 4'd8;
   localparam logic [3:0] STB_FIRST = 4'd7;
   localparam logic [3:0] STB_LAST  = 4'd13;
   localparam logic [3:0] DAT_FIRST = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT0  = 2'd1,
      ST_XFER   = 2'd2,
      ST_FINISH = 2'd3
   } seq_state_e;

   function automatic logic [7:0] unlock_byte(input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0:    b = SEQ0;
         3'd1:    b = SEQ1;
         3'd2:    b = SEQ2;
         3'd3:    b = SEQ3;
         3'd4:    b = SEQ4;
         3'd5:    b = SEQ5;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ram2e_bus_cycle.sv
// Free-running 6502 bus-cycle generator: phase counter, PHI1 and the
// registered row/strobe/data waveform of one $C073 write per bus cycle.
module ram2e_bus_cycle #(
   parameter int         CYCLE_LEN   = 14,
   parameter int         PHI1_HIGH   = 7,
   parameter logic [7:0] BANKREG_ROW = ram2e_pkg::BANKREG_ROW
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       wr_i,
   input  logic [7:0] byte_i,
   output logic [3:0] phase_nxt_o,
   output logic       phi1_o,
   output logic [7:0] ain_o,
   output logic [7:0] din_o,
   output logic       nwe_o,
   output logic       nc07x_o
);
   import ram2e_pkg::*;

   localparam logic [3:0] P_LAST   = 4'(CYCLE_LEN - 1);
   localparam logic [3:0] PHI1_END = 4'(PHI1_HIGH);

   logic [3:0] phase_q, phase_d;
   logic       phi1_q, phi1_d;
   logic [7:0] ain_q, ain_d;
   logic [7:0] din_q, din_d;
   logic       nwe_q, nwe_d;

   // wr_i/byte_i describe the bus cycle that phase_d belongs to, so every
   // output register holds the value for the phase it is displayed in.
   always_comb begin
      phase_d = (phase_q == P_LAST) ? 4'd0 : phase_q + 4'd1;
      phi1_d  = (phase_d < PHI1_END);
      ain_d   = 8'h00;
      din_d   = 8'h00;
      nwe_d   = 1'b1;
      if (wr_i) begin
         if (phase_d >= ROW_FIRST && phase_d <= ROW_LAST) ain_d = BANKREG_ROW;
         if (phase_d >= STB_FIRST && phase_d <= STB_LAST) nwe_d = 1'b0;
         if (phase_d >= DAT_FIRST) din_d = byte_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         phase_q <= P_LAST;
         phi1_q  <= 1'b0;
         ain_q   <= 8'h00;
         din_q   <= 8'h00;
         nwe_q   <= 1'b1;
      end else begin
         phase_q <= phase_d;
         phi1_q  <= phi1_d;
         ain_q   <= ain_d;
         din_q   <= din_d;
         nwe_q   <= nwe_d;
      end
   end

   assign phase_nxt_o = phase_d;
   assign phi1_o      = phi1_q;
   assign ain_o       = ain_q;
   assign din_o       = din_q;
   assign nwe_o       = nwe_q;
   assign nc07x_o     = nwe_q;

endmodule

// File: rtl/ram2e_cmd_initiator.sv
// Apple IIe-side initiator for the RAM2E bank-register command interface:
// sends the unlock sequence + command (+ arg), or a single bank write.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transfer; start accepted here
// ST_WAIT0  | request captured, waiting for the next bus-cycle wrap
// ST_XFER   | writing byte idx, one byte per bus cycle, no gaps
// ST_FINISH | last phase of the last byte; done pulses here
module ram2e_cmd_initiator #(
   parameter int         CYCLE_LEN   = 14,
   parameter int         PHI1_HIGH   = 7,
   parameter logic [7:0] BANKREG_ROW = ram2e_pkg::BANKREG_ROW
) (
   input  logic       C14M,
   input  logic       nRESET,
   input  logic       start,
   input  logic       single,
   input  logic [7:0] cmd,
   input  logic [7:0] arg,
   input  logic       has_arg,
   output logic       busy,
   output logic       done,
   output logic       PHI1,
   output logic [7:0] Ain,
   output logic [7:0] Din,
   output logic       nWE,
   output logic       nC07X,
   output logic       nWE80,
   output logic       nEN80
);
   import ram2e_pkg::*;

   localparam logic [3:0] P_LAST = 4'(CYCLE_LEN - 1);

   seq_state_e state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic       single_q, single_d;
   logic       has_arg_q, has_arg_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] arg_q, arg_d;

   logic [3:0] phase_nxt;
   logic [2:0] last_idx;
   logic       wr_nxt;
   logic [7:0] byte_nxt;

   assign last_idx = single_q ? 3'd0 : (has_arg_q ? 3'd7 : 3'd6);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      single_d  = single_q;
      has_arg_d = has_arg_q;
      cmd_d     = cmd_q;
      arg_d     = arg_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               single_d  = single;
               has_arg_d = has_arg;
               cmd_d     = cmd;
               arg_d     = arg;
               idx_d     = 3'd0;
               state_d   = ST_WAIT0;
            end
         end
         ST_WAIT0: begin
            if (phase_nxt == 4'd0) state_d = ST_XFER;
         end
         ST_XFER: begin
            if (phase_nxt == 4'd0) begin
               idx_d = idx_q + 3'd1;
            end else if (phase_nxt == P_LAST && idx_q == last_idx) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            idx_d   = 3'd0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Byte selection follows idx_d so Din lines up with the registered phase.
   always_comb begin
      wr_nxt = (state_d == ST_XFER) || (state_d == ST_FINISH);
      if (single_q)
         byte_nxt = arg_q;
      else if (idx_d < 3'd6)
         byte_nxt = unlock_byte(idx_d);
      else if (idx_d == 3'd6)
         byte_nxt = cmd_q;
      else
         byte_nxt = arg_q;
   end

   always_ff @(posedge C14M or negedge nRESET) begin
      if (!nRESET) begin
         state_q   <= ST_IDLE;
         idx_q     <= 3'd0;
         single_q  <= 1'b0;
         has_arg_q <= 1'b0;
         cmd_q     <= 8'h00;
         arg_q     <= 8'h00;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         single_q  <= single_d;
         has_arg_q <= has_arg_d;
         cmd_q     <= cmd_d;
         arg_q     <= arg_d;
      end
   end

   ram2e_bus_cycle #(
      .CYCLE_LEN  (CYCLE_LEN),
      .PHI1_HIGH  (PHI1_HIGH),
      .BANKREG_ROW(BANKREG_ROW)
   ) u_bus_cycle (
      .clk_i      (C14M),
      .rst_n_i    (nRESET),
      .wr_i       (wr_nxt),
      .byte_i     (byte_nxt),
      .phase_nxt_o(phase_nxt),
      .phi1_o     (PHI1),
      .ain_o      (Ain),
      .din_o      (Din),
      .nwe_o      (nWE),
      .nc07x_o    (nC07X)
   );

   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_FINISH);
   assign nWE80 = 1'b1;
   assign nEN80 = 1'b1;

endmodule

// File: tb/tb_ram2e_cmd_initiator.sv
// Scoreboard bench for ram2e_cmd_initiator: stimulus queues expected bytes
// and cycle counts, a negedge monitor checks each bus cycle and done pulse.
module tb_ram2e_cmd_initiator;

   logic       C14M = 1'b0;
   logic       nRESET = 1'b0;
   logic       start = 1'b0;
   logic       single = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic [7:0] arg = 8'h00;
   logic       has_arg = 1'b0;
   logic       busy, done, PHI1, nWE, nC07X, nWE80, nEN80;
   logic [7:0] Ain, Din;

   ram2e_cmd_initiator dut (
      .C14M(C14M), .nRESET(nRESET), .start(start), .single(single),
      .cmd(cmd), .arg(arg), .has_arg(has_arg), .busy(busy), .done(done),
      .PHI1(PHI1), .Ain(Ain), .Din(Din), .nWE(nWE), .nC07X(nC07X),
      .nWE80(nWE80), .nEN80(nEN80)
   );

   initial forever #5 C14M = ~C14M;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] exp_b[$];
   int         exp_len[$];

   int         phase = 13;
   logic       prev_phi = 1'b0;
   logic       in_wr = 1'b0;
   logic       prev_wr = 1'b0;
   int         wr_cnt = 0;
   logic [7:0] cur_b = 8'h00;
   int         n_done = 0;
   logic       busy_chk = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: condition not met (got violation, expected none)", name);
   endtask

   // Monitor: bench-side phase tracker re-syncs on every PHI1 rising edge.
   always @(negedge C14M) begin
      if (!nRESET) begin
         phase    = 13;
         prev_phi = 1'b0;
         in_wr    = 1'b0;
         prev_wr  = 1'b0;
         wr_cnt   = 0;
         busy_chk = 1'b0;
      end else begin
         phase    = (PHI1 && !prev_phi) ? 0 : phase + 1;
         prev_phi = PHI1;
         if (busy_chk) begin
            chk("busy_after_done", busy, 0);
            busy_chk = 1'b0;
         end
         case (phase)
            0: begin prev_wr = in_wr; in_wr = 1'b0; end
            6: if (!nWE || !nC07X) fail("strobe_before_p7");
            7: begin
               in_wr = !nWE;
               if (in_wr) begin
                  chk("ain_p7", Ain, 'h73);
                  chk("nc07x_p7", nC07X, 0);
                  chk("din_p7", Din, 0);
                  if (wr_cnt > 0) chk("no_idle_gap", prev_wr, 1);
               end
            end
            9:  if (in_wr) chk("ain_p9", Ain, 0);
            10: if (!in_wr && (!nWE || !nC07X || Din != 8'h00)) fail("stray_write");
            12: if (in_wr) begin
               if (exp_b.size() == 0) fail("unexpected_write");
               else begin
                  cur_b = exp_b.pop_front();
                  chk("din_p12", Din, cur_b);
               end
               wr_cnt++;
            end
            13: if (in_wr) begin
               chk("nwe_p13", nWE, 0);
               chk("din_p13", Din, cur_b);
            end
            default: ;
         endcase
         if (done) begin
            chk("done_phase", phase, 13);
            if (exp_len.size() == 0) fail("unexpected_done");
            else chk("cycle_count", wr_cnt, exp_len.pop_front());
            wr_cnt   = 0;
            n_done++;
            busy_chk = 1'b1;
         end
      end
   end

   task automatic wait_phase(input int ph);
      int n = 0;
      do begin
         @(negedge C14M); #1;
         n++;
      end while (phase != ph && n < 100);
      if (phase != ph) fail("wait_phase_timeout");
   endtask

   task automatic pulse_start(input logic s, input logic [7:0] c, input logic [7:0] a,
                              input logic h, input int ph);
      wait_phase(ph);
      single = s; cmd = c; arg = a; has_arg = h;
      start = 1'b1;
      @(negedge C14M); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic issue(input logic s, input logic [7:0] c, input logic [7:0] a,
                        input logic h, input int ph);
      if (s) begin
         exp_b.push_back(a);
         exp_len.push_back(1);
      end else begin
         exp_b.push_back(8'hFF); exp_b.push_back(8'h00); exp_b.push_back(8'h55);
         exp_b.push_back(8'hAA); exp_b.push_back(8'hC1); exp_b.push_back(8'hAD);
         exp_b.push_back(c);
         if (h) exp_b.push_back(a);
         exp_len.push_back(h ? 8 : 7);
      end
      pulse_start(s, c, a, h, ph);
   endtask

   task automatic wait_done(input string name);
      int target = n_done + 1;
      int n = 0;
      while (n_done < target && n < 300) begin
         @(negedge C14M); #1;
         n++;
      end
      if (n_done < target) fail(name);
   endtask

   task automatic wait_wr(input int cnt, input int ph);
      int n = 0;
      while (!(wr_cnt == cnt && phase == ph) && n < 300) begin
         @(negedge C14M); #1;
         n++;
      end
      if (!(wr_cnt == cnt && phase == ph)) fail("wait_write_timeout");
   endtask

   initial begin
      int hi, rises, viol, nd, n;
      logic pp;

      #12;
      chk("rst_phi1", PHI1, 0);
      chk("rst_nwe", nWE, 1);
      chk("rst_nc07x", nC07X, 1);
      chk("rst_nwe80", nWE80, 1);
      chk("rst_nen80", nEN80, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_din", Din, 0);
      chk("rst_ain", Ain, 0);

      @(negedge C14M); #1;
      nRESET = 1'b1;

      hi = 0; rises = 0; viol = 0; pp = 1'b0;
      repeat (42) begin
         @(negedge C14M); #1;
         hi += int'(PHI1);
         if (PHI1 && !pp) rises++;
         pp = PHI1;
         if (!nWE || !nC07X || Ain != 8'h00 || busy || done) viol++;
      end
      chk("idle_phi1_high_ticks", hi, 21);
      chk("idle_phi1_rises", rises, 3);
      chk("idle_violations", viol, 0);

      issue(1'b0, 8'hE0, 8'h3F, 1'b1, 5);
      wait_done("done_setmask");

      issue(1'b1, 8'h00, 8'h05, 1'b0, 3);
      wait_done("done_single");

      issue(1'b0, 8'hEF, 8'h99, 1'b0, 9);
      wait_wr(3, 4);
      pulse_start(1'b1, 8'h77, 8'h77, 1'b0, 5);
      wait_done("done_program");

      issue(1'b0, 8'hEE, 8'h12, 1'b1, 2);
      wait_wr(2, 10);
      chk("nwe_before_reset", nWE, 0);
      nRESET = 1'b0;
      #1;
      chk("midrst_nwe", nWE, 1);
      chk("midrst_nc07x", nC07X, 1);
      chk("midrst_phi1", PHI1, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_din", Din, 0);
      chk("midrst_ain", Ain, 0);
      exp_b.delete();
      exp_len.delete();
      nd = n_done;
      repeat (5) @(negedge C14M);
      #1;
      nRESET = 1'b1;
      repeat (30) @(negedge C14M);
      #1;
      chk("no_done_after_abort", n_done, nd);
      issue(1'b0, 8'hFF, 8'h00, 1'b0, 11);
      wait_done("done_after_reset");

      issue(1'b1, 8'h00, 8'hA5, 1'b0, 0);
      n = 0;
      while (nWE && n < 60) begin
         @(negedge C14M); #1;
         n++;
      end
      chk("p0_start_latency", n, 20);
      wait_done("done_p0_start");

      repeat (20) @(negedge C14M);
      #1;
      chk("queue_drained", exp_b.size() + exp_len.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
